// File: rtl/hps_cmd_pkg.sv
// Shared constants for the HPS command assembler: framing bytes, register
// addresses, FSM state encodings and the saturating-increment helper.
package hps_cmd_pkg;

  localparam int         PAYLOAD_BYTES = 6;
  localparam logic [7:0] SYNC_BYTE     = 8'hFF;

  localparam logic [3:0] ADDR_DATA  = 4'd0;
  localparam logic [3:0] ADDR_ABORT = 4'd1;
  localparam logic [3:0] ADDR_CLEAR = 4'd2;

  typedef logic [1:0] state_t;
  localparam state_t ST_SYNC    = 2'd0;
  localparam state_t ST_PAYLOAD = 2'd1;
  localparam state_t ST_CSUM    = 2'd2;
  localparam state_t ST_HOLD    = 2'd3;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/sat_counter8.sv
// 8-bit counter that sticks at 255; a clear on the same edge as an
// increment wins.
module sat_counter8
  import hps_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       inc,
  output logic [7:0] count
);

  logic [7:0] count_r;

  // count register: reset, then clear, then saturating increment
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= 8'd0;
    end else if (clear) begin
      count_r <= 8'd0;
    end else if (inc) begin
      count_r <= sat_inc8(count_r);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/hps_cmd_assembler.sv
// Builds 48-bit render commands from byte-wide HPS writes (sync + payload,
// plus an XOR checksum byte when HPS_CMD_CHECKSUM_EN is defined).
module hps_cmd_assembler #(
  parameter int         PAYLOAD_BYTES = hps_cmd_pkg::PAYLOAD_BYTES,
  parameter logic [7:0] SYNC_BYTE     = hps_cmd_pkg::SYNC_BYTE
) (
  input  logic                       clk50,
  input  logic                       reset,
  input  logic [7:0]                 hps_writedata,
  input  logic                       hps_write,
  input  logic                       hps_chipselect,
  input  logic [3:0]                 hps_address,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic [8*PAYLOAD_BYTES-1:0] cmd_data,
  output logic [7:0]                 drop_count,
  output logic [7:0]                 err_count
);

  import hps_cmd_pkg::*;

  localparam int DATA_W = 8 * PAYLOAD_BYTES;
  localparam int IDX_W  = (PAYLOAD_BYTES > 2) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);

  logic              wr_s, data_wr_s, abort_wr_s, clear_wr_s;
  state_t            state_r, state_nx;
  logic [IDX_W-1:0]  idx_r, idx_nx;
  logic [DATA_W-1:0] asm_r, asm_nx;
  logic              valid_r, valid_nx;
  logic              drop_inc_s;
`ifdef HPS_CMD_CHECKSUM_EN
  logic [7:0]        csum_r, csum_nx;
  logic              err_inc_s;
`endif

  assign wr_s       = hps_write & hps_chipselect;
  assign data_wr_s  = wr_s & (hps_address == ADDR_DATA);
  assign abort_wr_s = wr_s & (hps_address == ADDR_ABORT);
  assign clear_wr_s = wr_s & (hps_address == ADDR_CLEAR);

  // next-state, assembly and counter-increment decode
  always_comb begin
    state_nx   = state_r;
    idx_nx     = idx_r;
    asm_nx     = asm_r;
    valid_nx   = valid_r;
    drop_inc_s = 1'b0;
`ifdef HPS_CMD_CHECKSUM_EN
    csum_nx    = csum_r;
    err_inc_s  = 1'b0;
`endif
    case (state_r)
      ST_SYNC: begin
        if (data_wr_s && (hps_writedata == SYNC_BYTE)) begin
          state_nx = ST_PAYLOAD;
          idx_nx   = {IDX_W{1'b0}};
        end else if (data_wr_s) begin
          drop_inc_s = 1'b1;
        end else begin
          state_nx = ST_SYNC;
        end
      end
      ST_PAYLOAD: begin
        if (abort_wr_s) begin
          state_nx = ST_SYNC;
        end else if (data_wr_s) begin
          // framing is purely by count, so 0xFF here is ordinary payload
          asm_nx = {asm_r[DATA_W-9:0], hps_writedata};
          idx_nx = idx_r + IDX_W'(1);
`ifdef HPS_CMD_CHECKSUM_EN
          csum_nx = (idx_r == {IDX_W{1'b0}}) ? hps_writedata : (csum_r ^ hps_writedata);
`endif
          if (idx_r == LAST_IDX) begin
`ifdef HPS_CMD_CHECKSUM_EN
            state_nx = ST_CSUM;
`else
            state_nx = ST_HOLD;
            valid_nx = 1'b1;
`endif
          end else begin
            state_nx = ST_PAYLOAD;
          end
        end else begin
          state_nx = ST_PAYLOAD;
        end
      end
`ifdef HPS_CMD_CHECKSUM_EN
      ST_CSUM: begin
        if (abort_wr_s) begin
          state_nx = ST_SYNC;
        end else if (data_wr_s && (hps_writedata == csum_r)) begin
          state_nx = ST_HOLD;
          valid_nx = 1'b1;
        end else if (data_wr_s) begin
          state_nx  = ST_SYNC;
          err_inc_s = 1'b1;
        end else begin
          state_nx = ST_CSUM;
        end
      end
`endif
      ST_HOLD: begin
        // abort is ignored here: once raised, valid must not retract
        drop_inc_s = data_wr_s;
        if (valid_r && cmd_ready) begin
          state_nx = ST_SYNC;
          valid_nx = 1'b0;
        end else begin
          state_nx = ST_HOLD;
        end
      end
      default: begin
        state_nx = ST_SYNC;
        valid_nx = 1'b0;
      end
    endcase
  end

  // FSM and datapath registers
  always_ff @(posedge clk50) begin
    if (reset) begin
      state_r <= ST_SYNC;
      idx_r   <= {IDX_W{1'b0}};
      asm_r   <= {DATA_W{1'b0}};
      valid_r <= 1'b0;
`ifdef HPS_CMD_CHECKSUM_EN
      csum_r  <= 8'd0;
`endif
    end else begin
      state_r <= state_nx;
      idx_r   <= idx_nx;
      asm_r   <= asm_nx;
      valid_r <= valid_nx;
`ifdef HPS_CMD_CHECKSUM_EN
      csum_r  <= csum_nx;
`endif
    end
  end

  assign cmd_valid = valid_r;
  assign cmd_data  = asm_r;

  sat_counter8 u_drop (
    .clk   (clk50),
    .reset (reset),
    .clear (clear_wr_s),
    .inc   (drop_inc_s),
    .count (drop_count)
  );

`ifdef HPS_CMD_CHECKSUM_EN
  sat_counter8 u_err (
    .clk   (clk50),
    .reset (reset),
    .clear (clear_wr_s),
    .inc   (err_inc_s),
    .count (err_count)
  );
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_hps_cmd_assembler.sv
// Scoreboard bench for hps_cmd_assembler; checksum cases run only when
// HPS_CMD_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module tb_hps_cmd_assembler;

  logic        clk50 = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  hps_writedata = 8'd0;
  logic        hps_write = 1'b0;
  logic        hps_chipselect = 1'b0;
  logic [3:0]  hps_address = 4'd0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [47:0] cmd_data;
  logic [7:0]  drop_count;
  logic [7:0]  err_count;

  int tests = 0;
  int fails = 0;
  logic [47:0] sb_q[$];

  hps_cmd_assembler dut (
    .clk50          (clk50),
    .reset          (reset),
    .hps_writedata  (hps_writedata),
    .hps_write      (hps_write),
    .hps_chipselect (hps_chipselect),
    .hps_address    (hps_address),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_data       (cmd_data),
    .drop_count     (drop_count),
    .err_count      (err_count)
  );

  always #10 clk50 = ~clk50;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that registers the write.
  task automatic write_byte(input logic [3:0] addr, input logic [7:0] data);
    hps_address    = addr;
    hps_writedata  = data;
    hps_write      = 1'b1;
    hps_chipselect = 1'b1;
    @(posedge clk50);
    #1;
    hps_write      = 1'b0;
    hps_chipselect = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk50);
      #1;
    end
  endtask

  task automatic send_frame(input logic [47:0] p);
    logic [7:0] x;
    x = 8'd0;
    write_byte(4'd0, 8'hFF);
    for (int i = 0; i < 6; i++) begin
      write_byte(4'd0, p[47-8*i -: 8]);
      x = x ^ p[47-8*i -: 8];
    end
`ifdef HPS_CMD_CHECKSUM_EN
    write_byte(4'd0, x);
`endif
  endtask

  // monitor: a transfer happens on the next rising edge whenever valid & ready
  initial begin
    logic [47:0] exp;
    forever begin
      @(negedge clk50);
      if (!reset && cmd_valid && cmd_ready) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_cmd: got %0h expected none at %0t", cmd_data, $time);
        end else begin
          exp = sb_q.pop_front();
          check("cmd_data", {16'd0, cmd_data}, {16'd0, exp});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] held;
    idle(2);
    reset = 1'b0;
    check("rst_valid", {63'd0, cmd_valid}, 64'd0);
    check("rst_data", {16'd0, cmd_data}, 64'd0);
    check("rst_drop", {56'd0, drop_count}, 64'd0);
    check("rst_err", {56'd0, err_count}, 64'd0);

    // basic frame, ready high: valid for exactly one cycle
    cmd_ready = 1'b1;
    sb_q.push_back(48'h010203040506);
    send_frame(48'h010203040506);
    check("t1_valid_hi", {63'd0, cmd_valid}, 64'd1);
    idle(1);
    check("t1_valid_lo", {63'd0, cmd_valid}, 64'd0);

    // stall in HOLD, extra writes dropped
    cmd_ready = 1'b0;
    sb_q.push_back(48'hAABBCCDDEEFF);
    send_frame(48'hAABBCCDDEEFF);
    held = 48'hAABBCCDDEEFF;
    for (int i = 0; i < 10; i++) begin
      check("t2_hold_valid", {63'd0, cmd_valid}, 64'd1);
      check("t2_hold_data", {16'd0, cmd_data}, {16'd0, held});
      idle(1);
    end
    write_byte(4'd0, 8'h11);
    write_byte(4'd0, 8'hFF);
    write_byte(4'd1, 8'h00);
    write_byte(4'd0, 8'h22);
    check("t2_drop", {56'd0, drop_count}, 64'd3);
    check("t2_still_valid", {63'd0, cmd_valid}, 64'd1);
    check("t2_data", {16'd0, cmd_data}, {16'd0, held});
    cmd_ready = 1'b1;
    idle(1);
    check("t2_valid_lo", {63'd0, cmd_valid}, 64'd0);
    write_byte(4'd2, 8'h00);
    check("clr_drop", {56'd0, drop_count}, 64'd0);

    // drops in SYNC, abort a partial frame, then a full frame
    write_byte(4'd0, 8'h12);
    write_byte(4'd0, 8'h34);
    write_byte(4'd0, 8'hFF);
    write_byte(4'd0, 8'h01);
    write_byte(4'd0, 8'h02);
    write_byte(4'd1, 8'h5A);
    sb_q.push_back(48'h101112131415);
    send_frame(48'h101112131415);
    idle(2);
    check("t3_drop", {56'd0, drop_count}, 64'd2);

`ifdef HPS_CMD_CHECKSUM_EN
    sb_q.push_back(48'h010204081020);
    write_byte(4'd0, 8'hFF);
    write_byte(4'd0, 8'h01); write_byte(4'd0, 8'h02); write_byte(4'd0, 8'h04);
    write_byte(4'd0, 8'h08); write_byte(4'd0, 8'h10); write_byte(4'd0, 8'h20);
    write_byte(4'd0, 8'h3F);
    check("cs_good_valid", {63'd0, cmd_valid}, 64'd1);
    idle(1);
    write_byte(4'd0, 8'hFF);
    write_byte(4'd0, 8'h01); write_byte(4'd0, 8'h02); write_byte(4'd0, 8'h04);
    write_byte(4'd0, 8'h08); write_byte(4'd0, 8'h10); write_byte(4'd0, 8'h20);
    write_byte(4'd0, 8'h00);
    check("cs_bad_valid", {63'd0, cmd_valid}, 64'd0);
    check("cs_bad_err", {56'd0, err_count}, 64'd1);
    idle(2);
    check("cs_bad_valid2", {63'd0, cmd_valid}, 64'd0);
`else
    check("err_tied", {56'd0, err_count}, 64'd0);
`endif

    // saturation and clear
    for (int i = 0; i < 300; i++) write_byte(4'd0, 8'h00);
    check("sat_drop", {56'd0, drop_count}, 64'd255);
    write_byte(4'd0, 8'h07);
    check("sat_hold", {56'd0, drop_count}, 64'd255);
    write_byte(4'd2, 8'h00);
    check("sat_clear", {56'd0, drop_count}, 64'd0);
    check("clr_err", {56'd0, err_count}, 64'd0);

    // reset while holding a command: it must be lost
    cmd_ready = 1'b0;
    write_byte(4'd0, 8'h55);
    send_frame(48'hCAFEBABE0001);
    check("t5_hold_valid", {63'd0, cmd_valid}, 64'd1);
    check("t5_drop_pre", {56'd0, drop_count}, 64'd1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("t5_rst_valid", {63'd0, cmd_valid}, 64'd0);
    check("t5_rst_data", {16'd0, cmd_data}, 64'd0);
    check("t5_rst_drop", {56'd0, drop_count}, 64'd0);
    check("t5_rst_err", {56'd0, err_count}, 64'd0);
    cmd_ready = 1'b1;
    sb_q.push_back(48'h0F1E2D3C4B5A);
    send_frame(48'h0F1E2D3C4B5A);
    check("t5_valid", {63'd0, cmd_valid}, 64'd1);
    idle(3);
    check("sb_empty", {32'd0, 32'(sb_q.size())}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
